// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared encodings for the RGMII receive path
package rgmii_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GIG    = 2'd1,
        ST_NIB_LO = 2'd2,
        ST_NIB_HI = 2'd3
    } rx_state_t;

    // Bit positions of the in-band status carried on RXD between frames
    localparam int IB_LINK_BIT   = 0;
    localparam int IB_SPEED_LSB  = 1;
    localparam int IB_DUPLEX_BIT = 3;

    // Reserved speed code 2'b11 runs the byte-wide path like 1G
    function automatic logic is_gig(input logic [1:0] spd);
        return (spd != SPEED_10) && (spd != SPEED_100);
    endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// rtl/rgmii_inband_status.sv - debounce filter for RGMII in-band link status
module rgmii_inband_status
    import rgmii_pkg::*;
#(
    parameter int STATUS_FILTER = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dv,
    input  logic       er,
    input  logic [3:0] sample,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex
);

    localparam int CW = $clog2(STATUS_FILTER + 1);
    localparam logic [CW-1:0] FILT = CW'(STATUS_FILTER);

    logic [3:0]    prev;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // A zero count means no valid previous sample, so the run restarts at 1
    always_comb begin
        cnt_nxt = CW'(1);
        if (cnt != '0 && sample == prev) begin
            cnt_nxt = (cnt == FILT) ? cnt : cnt + CW'(1);
        end
    end

    // Track the run of identical idle samples and publish once it is long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            prev        <= '0;
            cnt         <= '0;
            link_up     <= 1'b0;
            link_speed  <= 2'b00;
            link_duplex <= 1'b0;
        end else if (dv || er) begin
            cnt <= '0;
        end else begin
            prev <= sample;
            cnt  <= cnt_nxt;
            if (cnt_nxt == FILT) begin
                link_up     <= sample[IB_LINK_BIT];
                link_speed  <= sample[IB_SPEED_LSB +: 2];
                link_duplex <= sample[IB_DUPLEX_BIT];
            end
        end
    end

endmodule

// File: rtl/rgmii_rx_ctrl.sv
// rtl/rgmii_rx_ctrl.sv - RGMII receive sequencer producing a GMII byte stream
module rgmii_rx_ctrl
    import rgmii_pkg::*;
#(
    parameter int STATUS_FILTER = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [3:0] rxd_q1,
    input  logic [3:0] rxd_q2,
    input  logic       rx_ctl_q1,
    input  logic       rx_ctl_q2,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_valid,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex
);

    logic      dv;
    logic      er;
    rx_state_t state;
    logic [3:0] low_nib;
    logic       er_acc;

    assign dv = rx_ctl_q1;
    assign er = rx_ctl_q1 ^ rx_ctl_q2;

    // Frame sequencer; the mode is fixed by the state chosen on leaving IDLE,
    // so a speed change mid-frame only matters at the next frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            low_nib    <= 4'h0;
            er_acc     <= 1'b0;
            gmii_rxd   <= 8'h00;
            gmii_rx_dv <= 1'b0;
            gmii_rx_er <= 1'b0;
            gmii_valid <= 1'b0;
        end else begin
            gmii_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dv) begin
                        if (is_gig(speed)) begin
                            gmii_rxd   <= {rxd_q2, rxd_q1};
                            gmii_rx_dv <= 1'b1;
                            gmii_rx_er <= er;
                            gmii_valid <= 1'b1;
                            state      <= ST_GIG;
                        end else begin
                            low_nib <= rxd_q1;
                            er_acc  <= er;
                            state   <= ST_NIB_HI;
                        end
                    end
                end
                ST_GIG: begin
                    gmii_rxd   <= {rxd_q2, rxd_q1};
                    gmii_rx_dv <= dv;
                    gmii_rx_er <= er;
                    gmii_valid <= 1'b1;
                    if (!dv) begin
                        state <= ST_IDLE;
                    end
                end
                ST_NIB_LO: begin
                    if (dv) begin
                        low_nib <= rxd_q1;
                        er_acc  <= er_acc | er;
                        state   <= ST_NIB_HI;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_NIB_HI: begin
                    gmii_rx_dv <= 1'b1;
                    gmii_valid <= 1'b1;
                    er_acc     <= 1'b0;
                    if (dv) begin
                        gmii_rxd   <= {rxd_q1, low_nib};
                        gmii_rx_er <= er_acc | er;
                        state      <= ST_NIB_LO;
                    end else begin
                        // Frame ended on a lone low nibble
                        gmii_rxd   <= {4'h0, low_nib};
                        gmii_rx_er <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rgmii_inband_status #(
        .STATUS_FILTER(STATUS_FILTER)
    ) u_inband (
        .clk        (clk),
        .rst        (rst),
        .dv         (dv),
        .er         (er),
        .sample     (rxd_q1),
        .link_up    (link_up),
        .link_speed (link_speed),
        .link_duplex(link_duplex)
    );

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
// tb/tb_rgmii_rx_ctrl.sv - directed self-checking bench for rgmii_rx_ctrl
module tb_rgmii_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speed = 2'b10;
    logic [3:0] rxd_q1 = 4'h0;
    logic [3:0] rxd_q2 = 4'h0;
    logic       rx_ctl_q1 = 1'b0;
    logic       rx_ctl_q2 = 1'b0;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_valid;
    logic       link_up;
    logic [1:0] link_speed;
    logic       link_duplex;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rgmii_rx_ctrl #(.STATUS_FILTER(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .speed      (speed),
        .rxd_q1     (rxd_q1),
        .rxd_q2     (rxd_q2),
        .rx_ctl_q1  (rx_ctl_q1),
        .rx_ctl_q2  (rx_ctl_q2),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .gmii_valid (gmii_valid),
        .link_up    (link_up),
        .link_speed (link_speed),
        .link_duplex(link_duplex)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Apply one cycle of iddr outputs, then sample just after the edge
    task automatic cyc(input logic [3:0] q1, input logic [3:0] q2, input logic c1, input logic c2);
        rxd_q1    = q1;
        rxd_q2    = q2;
        rx_ctl_q1 = c1;
        rx_ctl_q2 = c2;
        @(posedge clk);
        #1;
    endtask

    task automatic gig(input logic [7:0] b, input logic e);
        cyc(b[3:0], b[7:4], 1'b1, ~e);
    endtask

    task automatic idle(input logic [3:0] q1);
        cyc(q1, 4'h0, 1'b0, 1'b0);
    endtask

    // {valid, dv, er, rxd}
    function automatic logic [10:0] beat(input logic v, input logic d, input logic e, input logic [7:0] b);
        return {v, d, e, b};
    endfunction

    logic [10:0] obs_beat;
    assign obs_beat = {gmii_valid, gmii_rx_dv, gmii_rx_er, gmii_rxd};

    logic [7:0] pre [0:9];
    logic [7:0] b;

    initial begin
        pre[0] = 8'h55; pre[1] = 8'h55; pre[2] = 8'h55; pre[3] = 8'h55;
        pre[4] = 8'h55; pre[5] = 8'h55; pre[6] = 8'h55; pre[7] = 8'hD5;
        pre[8] = 8'h01; pre[9] = 8'h02;

        // Reset state, with a frame already on the wire
        rst = 1'b1;
        gig(8'hAA, 1'b0);
        gig(8'hAA, 1'b0);
        chk("rst_beat", obs_beat, 11'h000);
        chk("rst_link", {link_up, link_speed, link_duplex}, 4'h0);
        idle(4'h0);
        rst = 1'b0;

        // 1G preamble + 2 bytes, one clock latency, then the dv=0 beat
        speed = 2'b10;
        idle(4'h0);
        chk("gig_idle", obs_beat, 11'h000);
        for (int i = 0; i < 10; i++) begin
            gig(pre[i], 1'b0);
            chk($sformatf("gig_b%0d", i), obs_beat, beat(1'b1, 1'b1, 1'b0, pre[i]));
        end
        idle(4'h0);
        chk("gig_end", {gmii_valid, gmii_rx_dv}, 2'b10);
        idle(4'h0);
        chk("gig_after", gmii_valid, 1'b0);

        // 100M nibbles, low first, strobe every second clock
        speed = 2'b01;
        for (int i = 0; i < 8; i++) begin
            b = pre[i];
            cyc(b[3:0], 4'hF, 1'b1, 1'b1);
            chk($sformatf("nib_lo%0d", i), gmii_valid, 1'b0);
            cyc(b[7:4], 4'hF, 1'b1, 1'b1);
            chk($sformatf("nib_b%0d", i), obs_beat, beat(1'b1, 1'b1, 1'b0, pre[i]));
        end
        idle(4'h0);
        chk("nib_end", gmii_valid, 1'b0);

        // Odd nibble count: 1,2,3 -> 21 then error byte 03
        cyc(4'h1, 4'h0, 1'b1, 1'b1);
        chk("odd_n1", gmii_valid, 1'b0);
        cyc(4'h2, 4'h0, 1'b1, 1'b1);
        chk("odd_b21", obs_beat, beat(1'b1, 1'b1, 1'b0, 8'h21));
        cyc(4'h3, 4'h0, 1'b1, 1'b1);
        chk("odd_n3", gmii_valid, 1'b0);
        idle(4'h0);
        chk("odd_b03", obs_beat, beat(1'b1, 1'b1, 1'b1, 8'h03));
        idle(4'h0);
        chk("odd_after", gmii_valid, 1'b0);

        // Single dv cycle at 10M -> one odd-nibble error byte
        speed = 2'b00;
        cyc(4'h7, 4'h0, 1'b1, 1'b1);
        chk("one_n", gmii_valid, 1'b0);
        idle(4'h0);
        chk("one_b", obs_beat, beat(1'b1, 1'b1, 1'b1, 8'h07));

        // 1G with er on the 4th byte only
        speed = 2'b10;
        for (int i = 0; i < 8; i++) begin
            gig(8'h10 + 8'(i), i == 3);
            chk($sformatf("er_b%0d", i), obs_beat, beat(1'b1, 1'b1, i == 3, 8'h10 + 8'(i)));
        end
        idle(4'h0);
        chk("er_end", {gmii_valid, gmii_rx_dv, gmii_rx_er}, 3'b100);

        // Back-to-back 1G frames with a single dv=0 gap
        gig(8'hA1, 1'b0);
        chk("b2b_f1", obs_beat, beat(1'b1, 1'b1, 1'b0, 8'hA1));
        idle(4'h0);
        chk("b2b_gap", {gmii_valid, gmii_rx_dv}, 2'b10);
        gig(8'hB2, 1'b0);
        chk("b2b_f2", obs_beat, beat(1'b1, 1'b1, 1'b0, 8'hB2));
        idle(4'h0);

        // In-band status: 3 samples, false carrier breaks the run, then 4 samples
        for (int i = 0; i < 3; i++) begin
            idle(4'hD);
            chk($sformatf("ib_a%0d", i), link_up, 1'b0);
        end
        cyc(4'hD, 4'h0, 1'b0, 1'b1);
        chk("ib_fc", link_up, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(4'hD);
            chk($sformatf("ib_b%0d", i), link_up, 1'b0);
        end
        idle(4'hD);
        chk("ib_up", {link_up, link_speed, link_duplex}, 4'b1101);

        // dv breaks a run of new status; link held through the frame
        idle(4'h0);
        idle(4'h0);
        idle(4'h0);
        gig(8'h00, 1'b0);
        idle(4'h0);
        chk("ib_hold", {link_up, link_speed, link_duplex}, 4'b1101);

        // Speed change mid-frame stays in 1G until IDLE; reset mid-frame
        gig(8'hC0, 1'b0);
        speed = 2'b01;
        gig(8'hC1, 1'b0);
        chk("mid_c1", obs_beat, beat(1'b1, 1'b1, 1'b0, 8'hC1));
        gig(8'hC2, 1'b0);
        chk("mid_c2", obs_beat, beat(1'b1, 1'b1, 1'b0, 8'hC2));
        rst = 1'b1;
        gig(8'hC3, 1'b0);
        chk("mid_rst", obs_beat, 11'h000);
        chk("mid_rst_link", {link_up, link_speed, link_duplex}, 4'h0);
        rst = 1'b0;
        idle(4'h0);
        chk("mid_post", gmii_valid, 1'b0);
        cyc(4'hA, 4'h0, 1'b1, 1'b1);
        chk("nxt_lo", gmii_valid, 1'b0);
        cyc(4'hB, 4'h0, 1'b1, 1'b1);
        chk("nxt_b", obs_beat, beat(1'b1, 1'b1, 1'b0, 8'hBA));
        idle(4'h0);
        chk("nxt_end", gmii_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
